// File: rtl/ft245_sync_responder_if.sv
// Bus and host-side signal bundle for the FT245 synchronous responder.
// The slave modport is the responder; master is the controller/host side.
interface ft245_sync_responder_if;
    logic       usb_rxf_n;
    logic       usb_txe_n;
    logic       usb_oe_n;
    logic       usb_rd_n;
    logic       usb_wr_n;
    logic [7:0] usb_data_i;
    logic [7:0] usb_data_o;
    logic       usb_data_oe;
    logic       usb_siwu_n;
    logic       host_wr_en;
    logic [7:0] host_wr_data;
    logic       host_full;
    logic       host_rd_en;
    logic [7:0] host_rd_data;
    logic       host_rd_valid;
    logic       host_empty;
    logic       tx_flush;
    logic [2:0] err_flags;

    modport slave (
        output usb_rxf_n, usb_txe_n, usb_data_o, usb_data_oe,
        output host_full, host_rd_data, host_rd_valid, host_empty,
        output tx_flush, err_flags,
        input  usb_oe_n, usb_rd_n, usb_wr_n, usb_data_i, usb_siwu_n,
        input  host_wr_en, host_wr_data, host_rd_en
    );

    modport master (
        input  usb_rxf_n, usb_txe_n, usb_data_o, usb_data_oe,
        input  host_full, host_rd_data, host_rd_valid, host_empty,
        input  tx_flush, err_flags,
        output usb_oe_n, usb_rd_n, usb_wr_n, usb_data_i, usb_siwu_n,
        output host_wr_en, host_wr_data, host_rd_en
    );
endinterface

// File: rtl/ft245_sync_responder.sv
// Device-side FT245 synchronous FIFO responder: RX buffer feeds the bus,
// TX buffer captures bus writes, host side pushes/pops the other ends.
module ft245_sync_responder #(
    parameter int unsigned DEPTH = 128
) (
    input logic                   usb_clk_60m,
    input logic                   sys_rst,
    ft245_sync_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    rx_mem [DEPTH];
    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0] rx_count, tx_count;
    logic [CW-1:0] rx_count_next, tx_count_next;
    logic [AW-1:0] rx_rd_ptr_next;
    logic [7:0]    rx_head_next;
    logic          rx_push, rx_pop, tx_push, tx_pop;
    logic [2:0]    err_set;
    logic          siwu_q;

    assign bus.host_full  = (rx_count == CW'(DEPTH));
    assign bus.host_empty = (tx_count == '0);

    // Accept conditions, next counts and the byte that will sit at the RX head.
    always_comb begin
        rx_push        = bus.host_wr_en && !bus.host_full;
        rx_pop         = !bus.usb_oe_n && !bus.usb_rd_n && !bus.usb_rxf_n;
        tx_push        = !bus.usb_wr_n && !bus.usb_txe_n && bus.usb_oe_n;
        tx_pop         = bus.host_rd_en && !bus.host_empty;
        rx_count_next  = rx_count + CW'(rx_push) - CW'(rx_pop);
        tx_count_next  = tx_count + CW'(tx_push) - CW'(tx_pop);
        rx_rd_ptr_next = rx_rd_ptr + AW'(rx_pop);
        err_set        = {!bus.usb_wr_n && !bus.usb_oe_n,
                          !bus.usb_wr_n && bus.usb_txe_n,
                          !bus.usb_rd_n && bus.usb_rxf_n};
        rx_head_next   = 8'h00;
        if (rx_count_next != '0) begin
            // When the buffer drains to nothing this edge, the pushed byte becomes head.
            if (rx_push && (rx_count == CW'(rx_pop)))
                rx_head_next = bus.host_wr_data;
            else
                rx_head_next = rx_mem[rx_rd_ptr_next];
        end
    end

    always_ff @(posedge usb_clk_60m) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= bus.host_wr_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.usb_data_i;
    end

    always_ff @(posedge usb_clk_60m or posedge sys_rst) begin
        if (sys_rst) begin
            rx_wr_ptr         <= '0;
            rx_rd_ptr         <= '0;
            tx_wr_ptr         <= '0;
            tx_rd_ptr         <= '0;
            rx_count          <= '0;
            tx_count          <= '0;
            bus.usb_rxf_n     <= 1'b1;
            bus.usb_txe_n     <= 1'b1;
            bus.usb_data_o    <= 8'h00;
            bus.usb_data_oe   <= 1'b0;
            bus.host_rd_data  <= 8'h00;
            bus.host_rd_valid <= 1'b0;
            bus.tx_flush      <= 1'b0;
            bus.err_flags     <= 3'b000;
            siwu_q            <= 1'b1;
        end else begin
            rx_wr_ptr         <= rx_wr_ptr + AW'(rx_push);
            rx_rd_ptr         <= rx_rd_ptr_next;
            tx_wr_ptr         <= tx_wr_ptr + AW'(tx_push);
            tx_rd_ptr         <= tx_rd_ptr + AW'(tx_pop);
            rx_count          <= rx_count_next;
            tx_count          <= tx_count_next;
            bus.usb_rxf_n     <= (rx_count_next == '0);
            bus.usb_txe_n     <= (tx_count_next == CW'(DEPTH));
            bus.usb_data_o    <= rx_head_next;
            bus.usb_data_oe   <= ~bus.usb_oe_n;
            if (tx_pop) bus.host_rd_data <= tx_mem[tx_rd_ptr];
            bus.host_rd_valid <= tx_pop;
            siwu_q            <= bus.usb_siwu_n;
            bus.tx_flush      <= siwu_q && !bus.usb_siwu_n;
            bus.err_flags     <= bus.err_flags | err_set;
        end
    end
endmodule

// File: tb/tb_ft245_sync_responder.sv
// Randomized bench for ft245_sync_responder against a queue-based reference model.
module tb_ft245_sync_responder;
    localparam int unsigned DEPTH = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ft245_sync_responder_if bus ();

    ft245_sync_responder #(.DEPTH(DEPTH)) dut (
        .usb_clk_60m(clk),
        .sys_rst    (rst),
        .bus        (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_rd  = 0;
    int n_flush = 0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         m_rxf_n, m_txe_n, m_oe, m_rd_valid, m_flush, m_siwu_prev;
    logic [7:0] m_data_o, m_rd_data;
    logic [2:0] m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_rxf_n = 1; m_txe_n = 1; m_oe = 0; m_rd_valid = 0; m_flush = 0;
        m_siwu_prev = 1; m_data_o = 8'h00; m_rd_data = 8'h00; m_err = 3'b000;
    endtask

    task automatic idle_inputs();
        bus.usb_oe_n = 1; bus.usb_rd_n = 1; bus.usb_wr_n = 1; bus.usb_data_i = 8'h00;
        bus.usb_siwu_n = 1; bus.host_wr_en = 0; bus.host_wr_data = 8'h00; bus.host_rd_en = 0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_rxf_n"},   bus.usb_rxf_n, 1);
        check({pfx, "_txe_n"},   bus.usb_txe_n, 1);
        check({pfx, "_data_oe"}, bus.usb_data_oe, 0);
        check({pfx, "_data_o"},  bus.usb_data_o, 0);
        check({pfx, "_full"},    bus.host_full, 0);
        check({pfx, "_empty"},   bus.host_empty, 1);
        check({pfx, "_rd_data"}, bus.host_rd_data, 0);
        check({pfx, "_rd_valid"},bus.host_rd_valid, 0);
        check({pfx, "_flush"},   bus.tx_flush, 0);
        check({pfx, "_err"},     bus.err_flags, 0);
    endtask

    // One clock: apply current inputs, advance the model by the bus rules, compare at negedge.
    task automatic step();
        bit oe_n, rd_n, wr_n, siwu_n, wr_en, rd_en;
        bit rd_ok, push_ok, wr_ok, pop_ok;
        logic [7:0] din, hdin;
        oe_n = bus.usb_oe_n; rd_n = bus.usb_rd_n; wr_n = bus.usb_wr_n; siwu_n = bus.usb_siwu_n;
        wr_en = bus.host_wr_en; rd_en = bus.host_rd_en; din = bus.usb_data_i; hdin = bus.host_wr_data;
        rd_ok   = !oe_n && !rd_n && (rxq.size() != 0);
        push_ok = wr_en && (rxq.size() < DEPTH);
        wr_ok   = !wr_n && !m_txe_n && oe_n;
        pop_ok  = rd_en && (txq.size() != 0);
        if (rd_ok) check("bus_rd_byte", bus.usb_data_o, rxq[0]);
        if (!oe_n && !rd_n && !bus.usb_rxf_n) n_rd++;
        @(posedge clk);
        if (!rd_n && m_rxf_n)  m_err[0] = 1;
        if (!wr_n && m_txe_n)  m_err[1] = 1;
        if (!wr_n && !oe_n)    m_err[2] = 1;
        if (rd_ok) void'(rxq.pop_front());
        if (push_ok) rxq.push_back(hdin);
        if (pop_ok) m_rd_data = txq.pop_front();
        m_rd_valid = pop_ok;
        if (wr_ok) txq.push_back(din);
        m_rxf_n  = (rxq.size() == 0);
        m_data_o = (rxq.size() != 0) ? rxq[0] : 8'h00;
        m_txe_n  = (txq.size() == DEPTH);
        m_oe     = !oe_n;
        m_flush  = m_siwu_prev && !siwu_n;
        m_siwu_prev = siwu_n;
        @(negedge clk);
        if (bus.tx_flush) n_flush++;
        check("rxf_n",    bus.usb_rxf_n, m_rxf_n);
        check("txe_n",    bus.usb_txe_n, m_txe_n);
        check("data_o",   bus.usb_data_o, m_data_o);
        check("data_oe",  bus.usb_data_oe, m_oe);
        check("host_full",  bus.host_full, rxq.size() == DEPTH);
        check("host_empty", bus.host_empty, txq.size() == 0);
        check("rd_valid", bus.host_rd_valid, m_rd_valid);
        if (m_rd_valid) check("rd_data", bus.host_rd_data, m_rd_data);
        check("err_flags", bus.err_flags, m_err);
        check("tx_flush", bus.tx_flush, m_flush);
    endtask

    initial begin
        int rd_base, hi, lo;
        logic [7:0] seq[3];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        idle_inputs();
        model_reset();

        // Reset and release
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst = 0;
        step();
        check("rel_txe_low", bus.usb_txe_n, 0);
        check("rel_rxf_high", bus.usb_rxf_n, 1);

        // RX burst of three bytes then one underrun cycle
        for (int i = 0; i < 3; i++) begin
            bus.host_wr_en = 1; bus.host_wr_data = seq[i]; step();
        end
        bus.host_wr_en = 0;
        bus.usb_oe_n = 0; step();
        check("rx_oe_turn", bus.usb_data_oe, 1);
        check("rx_head", bus.usb_data_o, 8'h11);
        bus.usb_rd_n = 0;
        for (int i = 0; i < 3; i++) begin
            check("rx_burst_byte", bus.usb_data_o, seq[i]);
            step();
        end
        check("rx_drained", bus.usb_rxf_n, 1);
        step();
        check("rx_underrun", bus.err_flags[0], 1);
        idle_inputs(); step();

        // TX fill to full plus one dropped write
        for (int i = 0; i <= DEPTH; i++) begin
            bus.usb_wr_n = 0; bus.usb_data_i = 8'(i); step();
        end
        bus.usb_wr_n = 1;
        check("tx_full_txe", bus.usb_txe_n, 1);
        check("tx_overrun", bus.err_flags[1], 1);
        for (int i = 0; i < DEPTH; i++) begin
            bus.host_rd_en = 1; step();
            check("tx_pop_order", bus.host_rd_data, 8'(i));
        end
        step();
        check("tx_pop_empty", bus.host_rd_valid, 0);
        idle_inputs(); step();

        // Wrap-around with simultaneous push and read every cycle
        for (int i = 0; i < 5; i++) begin
            bus.host_wr_en = 1; bus.host_wr_data = 8'($urandom); step();
        end
        bus.host_wr_en = 0; bus.usb_oe_n = 0; step();
        rd_base = n_rd;
        bus.usb_rd_n = 0;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            bus.host_wr_en = 1; bus.host_wr_data = 8'($urandom); step();
        end
        bus.host_wr_en = 0;
        repeat (7) step();
        check("wrap_read_count", n_rd - rd_base, 3 * DEPTH + 5);
        idle_inputs(); step();

        // Contention and flush
        bus.usb_oe_n = 0; bus.usb_wr_n = 0; bus.usb_data_i = 8'hA5; step();
        idle_inputs(); step();
        check("contention_err", bus.err_flags[2], 1);
        check("contention_nowr", bus.host_empty, 1);
        n_flush = 0;
        bus.usb_siwu_n = 0; step();
        bus.usb_siwu_n = 1; repeat (4) step();
        check("flush_pulses", n_flush, 1);

        // Randomized traffic with alternating bias to reach both boundaries
        for (int seg = 0; seg < 4; seg++) begin
            hi = (seg % 2 == 0) ? 85 : 15;
            lo = 100 - hi;
            for (int i = 0; i < 600; i++) begin
                bus.host_wr_en   = ($urandom_range(99) < hi);
                bus.host_wr_data = 8'($urandom);
                bus.usb_oe_n     = ($urandom_range(99) < 90) ? 1'b0 : 1'b1;
                bus.usb_rd_n     = ($urandom_range(99) < lo) ? 1'b0 : 1'b1;
                bus.usb_wr_n     = ($urandom_range(99) < hi) ? 1'b0 : 1'b1;
                if (bus.usb_wr_n == 0) bus.usb_oe_n = ($urandom_range(99) < 95) ? 1'b1 : 1'b0;
                bus.usb_data_i   = 8'($urandom);
                bus.host_rd_en   = ($urandom_range(99) < lo);
                bus.usb_siwu_n   = ($urandom_range(99) < 10) ? 1'b0 : 1'b1;
                step();
            end
        end
        idle_inputs(); step();

        // Reset asserted in the middle of a 10-byte read
        for (int i = 0; i < 10; i++) begin
            bus.host_wr_en = 1; bus.host_wr_data = 8'(8'h40 + i); step();
        end
        bus.host_wr_en = 0; bus.usb_oe_n = 0; step();
        bus.usb_rd_n = 0; repeat (4) step();
        #2 rst = 1;
        #1 check_reset_vals("midrst");
        idle_inputs();
        model_reset();
        @(negedge clk);
        check_reset_vals("midrst_hold");
        rst = 0;
        step();
        bus.usb_oe_n = 0; bus.host_rd_en = 1; step();
        bus.usb_rd_n = 0; step();
        check("post_rst_empty_rx", bus.usb_data_o, 0);
        check("post_rst_underrun", bus.err_flags, 3'b001);
        idle_inputs(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ft245_sync_responder.md
# ft245_sync_responder

Synthesizable device-side model of an FT245-style synchronous FIFO interface, the responder on the other end of the FPGA-side USB read/write controller. It drives `usb_rxf_n`/`usb_txe_n`, sources bytes onto the data bus when the controller reads, and captures bytes when the controller writes. Two internal byte buffers connect the bus to a host-side push/pop interface. It is used for on-chip loopback bring-up and as the bus partner in controller benches.

## Interface
- `DEPTH`, 128, entries per buffer (RX and TX); power of two, ≥4
- `usb_clk_60m`  in  1  bus clock; all logic rises on it
- `sys_rst`  in  1  asynchronous, active-high reset
- `usb_rxf_n`  out  1  low = RX buffer holds data for the controller
- `usb_txe_n`  out  1  low = TX buffer can accept a byte
- `usb_oe_n`  in  1  controller output-enable request (bus turnaround)
- `usb_rd_n`  in  1  controller read strobe
- `usb_wr_n`  in  1  controller write strobe
- `usb_data_i`  in  8  bus data written by the controller
- `usb_data_o`  out  8  bus data driven toward the controller
- `usb_data_oe`  out  1  high = responder drives the bus
- `usb_siwu_n`  in  1  send-immediate request, active low
- `host_wr_en`  in  1  push `host_wr_data` into RX buffer
- `host_wr_data`  in  8  byte to push
- `host_full`  out  1  RX buffer full
- `host_rd_en`  in  1  pop one byte from TX buffer
- `host_rd_data`  out  8  popped byte
- `host_rd_valid`  out  1  `host_rd_data` valid this cycle
- `host_empty`  out  1  TX buffer empty
- `tx_flush`  out  1  one-cycle pulse on `usb_siwu_n` falling edge
- `err_flags`  out  3  sticky: [0] underrun, [1] overrun, [2] contention

## Operation
- Buffers: two circular RAMs, pointers `$clog2(DEPTH)` bits (wrap naturally), counts `$clog2(DEPTH)+1` bits.
- RX buffer (host → controller): first-word-fall-through; `usb_data_o` always shows the head byte (0 when empty).
- Host push: accepted when `host_wr_en && !host_full`; a push while full is dropped without changing state.
- Bus read: accepted at an edge where `usb_oe_n==0 && usb_rd_n==0 && usb_rxf_n==0` (registered value); head pointer advances.
- `usb_rd_n==0` with `usb_rxf_n==1`: no pop, set `err_flags[0]`.
- Bus write: accepted at an edge where `usb_wr_n==0 && usb_txe_n==0 && usb_oe_n==1`; `usb_data_i` is stored in the TX buffer.
- `usb_wr_n==0` with `usb_txe_n==1`: dropped, set `err_flags[1]`.
- `usb_wr_n==0` with `usb_oe_n==0`: dropped, set `err_flags[2]`; a read in the same cycle is still honoured.
- Host pop: accepted when `host_rd_en && !host_empty`. `host_rd_data` is registered and valid for one cycle with `host_rd_valid`. A pop while empty is ignored.
- Simultaneous push and pop on one buffer, including at full or empty boundaries where both are legal: both take effect and the count is unchanged.
- `tx_flush`: registered falling-edge detect of `usb_siwu_n`. Data flow is unaffected.
- `err_flags` clear only on reset.

## Timing
- Reset values: `usb_rxf_n=1`, `usb_txe_n=1`, `usb_data_oe=0`, `usb_data_o=0`, `host_full=0`, `host_empty=1`, `host_rd_data=0`, `host_rd_valid=0`, `tx_flush=0`, `err_flags=0`. Both buffers are empty.
- `usb_rxf_n` is registered: `usb_rxf_n <= (rx_count_next == 0)`.
  - The first host push makes it low one cycle later.
  - The pop of the last byte makes it high the next cycle, so no extra read is accepted.
- `usb_txe_n` is registered: `usb_txe_n <= (tx_count_next == DEPTH)`. It goes low on the first edge after reset release.
- `usb_data_oe <= ~usb_oe_n`, giving a one-cycle turnaround in both directions. Data is valid on the bus the cycle after `usb_oe_n` falls.
- Back-to-back reads: one byte per clock while `rd_n` is low. `usb_data_o` advances to the next byte the cycle after each accepted pop.
- Back-to-back writes: one byte per clock until full. `usb_txe_n` rises the cycle after the DEPTH-th write.
- Host pop latency: one cycle from `host_rd_en` to `host_rd_valid`.
- `host_full` and `host_empty` are combinational from the counts.
- Reset asserted mid-transfer: all state clears immediately (asynchronous). Buffered bytes are discarded and the bus is released (`usb_data_oe=0`).

## Test plan
- **Reset release:** one cycle after release, `usb_txe_n=0`, `usb_rxf_n=1`, `host_empty=1`, `err_flags=0`.
- **RX burst:** host pushes 0x11,0x22,0x33; controller drops `oe_n`, then holds `rd_n` low for 3 cycles. Bus delivers 0x11,0x22,0x33 on consecutive cycles; `usb_rxf_n` rises after the third; a 4th `rd_n` cycle sets `err_flags[0]`.
- **TX fill to full:** controller writes DEPTH bytes 0..DEPTH-1. `usb_txe_n=1` after the last; the extra write is dropped and sets `err_flags[1]`. Host pops return 0..DEPTH-1 in order, each one cycle after `host_rd_en`.
- **Wrap-around:** push/pop 3×DEPTH bytes through RX with simultaneous host push and bus read every cycle. Data matches in order and the count stays constant.
- **Contention and flush:** `wr_n=0` with `oe_n=0` gives no TX write and `err_flags[2]=1`. A one-cycle `usb_siwu_n` low gives exactly one `tx_flush` pulse.
- **Reset mid-burst:** assert `sys_rst` during a 10-byte read. All outputs return to reset values and the buffers are empty afterwards.
